// File: rtl/pipo_load_arb.sv
// Two-requester round-robin arbiter that drives load strobes into a 4-bit
// parallel-in/parallel-out register and enforces a hold-off period after each load.
module pipo_load_arb #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [3:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [3:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       load_o,
  output logic [3:0] data_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic [7:0] load_count_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_COOLDOWN = 2'd2;

  // The cooldown counter is loaded with the last index so it spends exactly HOLD_CYCLES cycles.
  localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       prio_q, prio_d;      // 1: requester 1 has priority
  logic       load_q, load_d;
  logic [3:0] data_q, data_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic [7:0] count_q, count_d;
  logic       win1;

  // Requester 1 wins when it is the only one asking, or when both ask and it holds priority.
  assign win1 = req1_valid_i & (~req0_valid_i | prio_q);

  // NOTE: every next-state variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    prio_d  = prio_q;
    load_d  = 1'b0;
    data_d  = data_q;
    grant_d = 2'b00;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          state_d = S_LOAD;
          load_d  = 1'b1;
          grant_d = win1 ? 2'b10 : 2'b01;
          data_d  = win1 ? req1_data_i : req0_data_i;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        count_d = count_q + 8'd1;
        prio_d  = grant_q[0];
        if (HOLD_CYCLES == 0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_COOLDOWN;
          hold_d  = HOLD_LAST;
        end
      end
      S_COOLDOWN: begin
        if (hold_q == 4'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments and are all cleared by the async reset,
  // so an in-flight load or cooldown is simply discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
      prio_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= 4'h0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      prio_q  <= prio_d;
      load_q  <= load_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Grant is non-zero only during LOAD, so each grant flop doubles as that requester's ready.
  assign req0_ready_o = grant_q[0];
  assign req1_ready_o = grant_q[1];
  assign load_o       = load_q;
  assign data_o       = data_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign load_count_o = count_q;

endmodule

// File: tb/tb_pipo_load_arb.sv
// Bench for pipo_load_arb: cycle table plus load scoreboard on a HOLD_CYCLES=2
// instance, and back-to-back / counter-wrap sequences on a HOLD_CYCLES=0 instance.
module tb_pipo_load_arb;

  logic clk = 1'b0;
  logic rst;

  logic       a_v0, a_v1, a_r0, a_r1, a_load, a_busy;
  logic [3:0] a_d0, a_d1, a_data;
  logic [1:0] a_grant;
  logic [7:0] a_cnt;

  logic       b_v0, b_v1, b_r0, b_r1, b_load, b_busy;
  logic [3:0] b_d0, b_d1, b_data;
  logic [1:0] b_grant;
  logic [7:0] b_cnt;

  pipo_load_arb #(.HOLD_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(a_v0), .req0_data_i(a_d0), .req0_ready_o(a_r0),
    .req1_valid_i(a_v1), .req1_data_i(a_d1), .req1_ready_o(a_r1),
    .load_o(a_load), .data_o(a_data), .grant_o(a_grant),
    .busy_o(a_busy), .load_count_o(a_cnt)
  );

  pipo_load_arb #(.HOLD_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(b_v0), .req0_data_i(b_d0), .req0_ready_o(b_r0),
    .req1_valid_i(b_v1), .req1_data_i(b_d1), .req1_ready_o(b_r1),
    .load_o(b_load), .data_o(b_data), .grant_o(b_grant),
    .busy_o(b_busy), .load_count_o(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       load;
    logic [3:0] data;
    logic [1:0] grant;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] grant;
  } ld_t;

  vec_t vecs[$];
  ld_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v0, input logic [3:0] d0,
                     input logic v1, input logic [3:0] d1,
                     input logic ld, input logic [3:0] dat, input logic [1:0] gnt,
                     input logic bsy, input logic [7:0] cnt);
    vec_t v;
    v.rst = r;  v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.load = ld; v.data = dat; v.grant = gnt; v.busy = bsy; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Scoreboard: every load seen on dut_a must match the next expected load.
  always @(posedge clk) begin : sb_mon
    ld_t e;
    #1;
    if (a_load === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_load", {31'd0, a_load}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", {28'd0, a_data}, {28'd0, e.data});
        check("sb_grant", {30'd0, a_grant}, {30'd0, e.grant});
        check("sb_ready", {30'd0, a_r1, a_r0}, {30'd0, e.grant});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_v0 = 0; a_d0 = 0; a_v1 = 0; a_d1 = 0;
    b_v0 = 0; b_d0 = 0; b_v1 = 0; b_d1 = 0;

    //  rst v0 d0    v1 d1    load data  grant  busy cnt
    add(1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 8'd0);
    add(0, 1, 4'h7, 0, 4'h0, 1, 4'h7, 2'b01, 1, 8'd0);  // single request
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h7, 2'b00, 1, 8'd1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h7, 2'b00, 1, 8'd1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h7, 2'b00, 0, 8'd1);
    add(0, 0, 4'h0, 1, 4'h5, 1, 4'h5, 2'b10, 1, 8'd1);  // req1 alone
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h5, 2'b00, 1, 8'd2);
    add(0, 1, 4'h9, 0, 4'h0, 0, 4'h5, 2'b00, 1, 8'd2);  // withdraw during cooldown
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h5, 2'b00, 0, 8'd2);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h5, 2'b00, 0, 8'd2);
    add(0, 1, 4'h3, 1, 4'hC, 1, 4'h3, 2'b01, 1, 8'd2);  // contention
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'h3, 2'b00, 1, 8'd3);
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'h3, 2'b00, 1, 8'd3);
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'h3, 2'b00, 0, 8'd3);
    add(0, 1, 4'h3, 1, 4'hC, 1, 4'hC, 2'b10, 1, 8'd3);
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'hC, 2'b00, 1, 8'd4);
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'hC, 2'b00, 1, 8'd4);
    add(0, 1, 4'h3, 1, 4'hC, 0, 4'hC, 2'b00, 0, 8'd4);
    add(0, 1, 4'h3, 1, 4'hC, 1, 4'h3, 2'b01, 1, 8'd4);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h3, 2'b00, 1, 8'd5);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h3, 2'b00, 1, 8'd5);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'h3, 2'b00, 0, 8'd5);
    add(0, 1, 4'hA, 0, 4'h0, 1, 4'hA, 2'b01, 1, 8'd5);  // req0 alone against pointer
    add(0, 1, 4'hF, 0, 4'h0, 0, 4'hA, 2'b00, 1, 8'd6);  // data change after arbitration
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'hA, 2'b00, 1, 8'd6);
    add(0, 0, 4'h0, 0, 4'h0, 0, 4'hA, 2'b00, 0, 8'd6);
    add(0, 1, 4'h6, 1, 4'h2, 1, 4'h2, 2'b10, 1, 8'd6);  // ends in LOAD

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      a_v0 = vecs[i].v0; a_d0 = vecs[i].d0;
      a_v1 = vecs[i].v1; a_d1 = vecs[i].d1;
      if (vecs[i].load) sb.push_back('{vecs[i].data, vecs[i].grant});
      @(posedge clk); #1;
      check($sformatf("row%0d", i),
            {14'd0, a_load, a_data, a_grant, a_r1, a_r0, a_busy, a_cnt},
            {14'd0, vecs[i].load, vecs[i].data, vecs[i].grant,
             vecs[i].grant[1], vecs[i].grant[0], vecs[i].busy, vecs[i].cnt});
    end

    // Reset in the middle of the LOAD cycle must clear everything at once.
    #1 rst = 1'b1;
    #1;
    check("rst_mid_load", {14'd0, a_load, a_data, a_grant, a_r1, a_r0, a_busy, a_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back('{4'h6, 2'b01});
    @(posedge clk); #1;
    check("post_rst_grant", {16'd0, a_load, a_data, a_grant, a_busy, a_cnt},
          {16'd0, 1'b1, 4'h6, 2'b01, 1'b1, 8'd0});
    a_v0 = 0; a_v1 = 0;
    @(posedge clk); #1;
    check("post_rst_count", {24'd0, a_cnt}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back loads with no cooldown.
    b_v1 = 1; b_d1 = 4'hD;
    for (int k = 1; k <= 6; k++) begin
      logic ld;
      @(posedge clk); #1;
      ld = (k % 2) == 1;
      check($sformatf("b2b%0d", k),
            {17'd0, b_load, b_r1, b_r0, b_grant, b_data, b_cnt},
            {17'd0, ld, ld, 1'b0, ld, 1'b0, 4'hD, 8'(k / 2)});
    end
    b_v1 = 0;

    // 256 loads wrap the counter back to zero.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b_v0 = 1; b_d0 = 4'(i);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i == 254) check("wrap_255", {24'd0, b_cnt}, 32'd255);
    end
    b_v0 = 0;
    check("wrap_cnt", {24'd0, b_cnt}, 32'd0);
    check("wrap_data", {28'd0, b_data}, 32'hF);

    @(posedge clk); #2;
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
